oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/naes_pkg.sv | 15 +
 rtl/oam_dma.sv | 95 +++++++++
 tb/tb_oam_dma.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/naes_pkg.sv
// Shared NES-core definitions: DMA state encoding and memory-mapped register addresses.
package naes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } oam_dma_state_t;

    localparam logic [15:0] OAMDMA_REG  = 16'h4014;
    localparam logic [15:0] OAMDATA_REG = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 copies page {page,00..FF} into OAMDATA, halting the CPU meanwhile.
// Latency: trigger edge -> HALT, then 256 read/write pairs; hijack 513 cycles (514 with an odd-cycle ALIGN).
// Backpressure: none; the CPU is stalled via dma_hijack. OAM_DMA_ALIGN_EN enables the odd-cycle ALIGN state.
module oam_dma
    import naes_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_or_even,
    input  logic [7:0]  mem_q,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_wr,
    output logic        dma_done
);

    oam_dma_state_t state_q, state_d;
    logic [7:0]     page_q, page_d;
    logic [7:0]     index_q, index_d;
    logic           done_d;

`ifndef OAM_DMA_ALIGN_EN
    logic unused_odd_or_even;
    assign unused_odd_or_even = odd_or_even;
`endif

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            dma_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            dma_done <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        index_d    = index_q;
        done_d     = 1'b0;
        dma_hijack = 1'b1;
        dma_addr   = 16'h0000;
        dma_dout   = 8'h00;
        dma_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dma_hijack = 1'b0;
                if (bus_wr && (bus_addr == OAMDMA_REG)) begin
                    page_d  = bus_din;
                    index_d = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = odd_or_even ? ST_ALIGN : ST_READ;
`else
                state_d = ST_READ;
`endif
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                dma_addr = {page_q, index_q};
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                // mem_q is the byte addressed during the preceding READ cycle
                dma_addr = OAMDATA_REG;
                dma_dout = mem_q;
                dma_wr   = 1'b1;
                index_d  = index_q + 8'h01;
                if (index_q == 8'hFF) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                dma_hijack = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected source addresses are queued at trigger time and popped per OAM write.
module tb_oam_dma;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic        odd_or_even;
    logic [7:0]  mem_q;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_wr;
    logic        dma_done;

`ifdef OAM_DMA_ALIGN_EN
    localparam int ODD_HIJACK = 514;
`else
    localparam int ODD_HIJACK = 513;
`endif

    int checks = 0;
    int passes = 0;
    int hij_tot = 0;
    int wr_tot = 0;
    int done_tot = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prev_addr = 16'h0000;
    bit          prev_wr = 1'b0;

    oam_dma dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_wr      (bus_wr),
        .odd_or_even (odd_or_even),
        .mem_q       (mem_q),
        .dma_hijack  (dma_hijack),
        .dma_addr    (dma_addr),
        .dma_dout    (dma_dout),
        .dma_wr      (dma_wr),
        .dma_done    (dma_done)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // synchronous RAM preloaded with ram_byte()
    always @(posedge cpu_clk) mem_q <= ram_byte(dma_addr);

    // Advance one cycle and score whatever the DUT did in it.
    task automatic step();
        logic [15:0] e;
        @(negedge cpu_clk);
        if (dma_hijack === 1'b1) hij_tot++;
        if (dma_hijack === 1'b0) begin
            checks++;
            if (dma_wr !== 1'b0 || dma_addr !== 16'h0000 || dma_dout !== 8'h00)
                $display("FAIL idle_outputs wr=%b addr=%h dout=%h required 0/0000/00", dma_wr, dma_addr, dma_dout);
            else passes++;
        end
        if (dma_done === 1'b1) begin
            done_tot++;
            checks++;
            if (!prev_wr || dma_hijack !== 1'b0)
                $display("FAIL done_timing prev_wr=%b hijack=%b required 1/0", prev_wr, dma_hijack);
            else passes++;
        end
        if (dma_wr === 1'b1) begin
            wr_tot++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h dout=%h required no write", dma_addr, dma_dout);
            end else begin
                e = exp_q.pop_front();
                if (prev_addr !== e || dma_addr !== 16'h2004 || dma_dout !== ram_byte(e))
                    $display("FAIL oam_write read=%h addr=%h dout=%h required %h/2004/%h",
                             prev_addr, dma_addr, dma_dout, e, ram_byte(e));
                else passes++;
            end
        end
        prev_addr = dma_addr;
        prev_wr   = (dma_wr === 1'b1);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a;
        bus_din  = d;
        bus_wr   = 1'b1;
        step();
        bus_wr   = 1'b0;
        bus_addr = 16'h0000;
        bus_din  = 8'h00;
    endtask

    task automatic push_page(input logic [7:0] page);
        for (int i = 0; i < 256; i++) exp_q.push_back({page, 8'(i)});
    endtask

    task automatic run_xfer(input logic [7:0] page, input logic odd, input int exp_hij, input bit poke);
        int  h0, w0, d0, n;
        bit  poked;
        h0 = hij_tot; w0 = wr_tot; d0 = done_tot; poked = 1'b0;
        odd_or_even = odd;
        push_page(page);
        bus_write(16'h4014, page);
        for (n = 0; n < 2000 && (done_tot - d0) == 0; n++) begin
            if (poke && !poked && (wr_tot - w0) == 50) begin
                bus_write(16'h4014, ~page);
                poked = 1'b1;
            end else begin
                step();
            end
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (n >= 2000) $display("FAIL xfer_timeout page=%h cycles=%0d required done within 2000", page, n);
        else passes++;
        checks++;
        if (hij_tot - h0 != exp_hij) $display("FAIL hijack_len page=%h got %0d required %0d", page, hij_tot - h0, exp_hij);
        else passes++;
        checks++;
        if (wr_tot - w0 != 256) $display("FAIL write_count page=%h got %0d required 256", page, wr_tot - w0);
        else passes++;
        checks++;
        if (done_tot - d0 != 1) $display("FAIL done_count page=%h got %0d required 1", page, done_tot - d0);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL queue_left page=%h got %0d required 0", page, exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_wr = 1'b0; bus_addr = 16'h0000; bus_din = 8'h00; odd_or_even = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if (dma_hijack !== 1'b0 || dma_wr !== 1'b0 || dma_addr !== 16'h0000 || dma_dout !== 8'h00 || dma_done !== 1'b0)
            $display("FAIL reset_state hij=%b wr=%b addr=%h dout=%h done=%b required all 0",
                     dma_hijack, dma_wr, dma_addr, dma_dout, dma_done);
        else passes++;
    endtask

    task automatic test_reset_priority();
        int h0;
        h0 = hij_tot;
        reset = 1'b1;
        bus_write(16'h4014, 8'h05);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (hij_tot != h0) $display("FAIL reset_priority hijack_cycles=%0d required 0", hij_tot - h0);
        else passes++;
    endtask

    task automatic test_bad_addr();
        int h0;
        h0 = hij_tot;
        bus_write(16'h4015, 8'h02);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (hij_tot != h0) $display("FAIL bad_addr hijack_cycles=%0d required 0", hij_tot - h0);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int w0, n;
        w0 = wr_tot;
        odd_or_even = 1'b0;
        push_page(8'h03);
        bus_write(16'h4014, 8'h03);
        for (n = 0; n < 1000 && (wr_tot - w0) < 100; n++) step();
        checks++;
        if ((wr_tot - w0) != 100) $display("FAIL mid_reset_reach writes=%0d required 100", wr_tot - w0);
        else passes++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (dma_hijack !== 1'b0 || dma_wr !== 1'b0) $display("FAIL mid_reset_out hij=%b wr=%b required 0/0", dma_hijack, dma_wr);
        else passes++;
        exp_q.delete();
        w0 = wr_tot;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (wr_tot != w0) $display("FAIL mid_reset_quiet writes=%0d required 0", wr_tot - w0);
        else passes++;
        run_xfer(8'h04, 1'b0, 513, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reset_priority();
        run_xfer(8'h02, 1'b0, 513, 1'b0);
        run_xfer(8'h02, 1'b1, ODD_HIJACK, 1'b0);
        run_xfer(8'hFF, 1'b0, 513, 1'b0);
        test_bad_addr();
        run_xfer(8'h11, 1'b1, ODD_HIJACK, 1'b1);
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
